// File: rtl/alu_pkg.sv
// Shared definitions for the serial nibble-wide arithmetic units.
package alu_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of the nibble index for a WIDTH-bit operand.
  function automatic int idx_width(input int width);
    return $clog2(width / NIBBLE);
  endfunction

endpackage

// File: rtl/sub16_serial_bla4.sv
// 4-bit borrow-lookahead subtract slice: computes inA - inB - bIn for one nibble.
module bla4 (
  input  logic [3:0] inA,
  input  logic [3:0] inB,
  input  logic       bIn,
  output logic [3:0] diff,
  output logic       bOut
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] bw;

  assign g = ~inA & inB;
  assign p = ~(inA ^ inB);

  // Every internal borrow is a flat sum of products of g, p and bIn.
  assign bw[1] = g[0] | (p[0] & bIn);
  assign bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bIn);
  assign bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bIn);
  assign bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bIn);

  assign diff = inA ^ inB ^ {bw[3:1], bIn};
  assign bOut = bw[4];

endmodule

// File: rtl/sub16_serial.sv
// Multi-cycle subtractor: inA - inB - bIn, one nibble per cycle LSB first,
// with registered flags that only change on the last-nibble edge.
module sub16_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             bIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bOut,
  output logic             ovf,
  output logic             zero
);

  localparam int NIBS = WIDTH / NIBBLE;
  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(NIBS - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [3:0] nib_diff;
  logic       nib_bout;

  bla4 u_bla4 (
    .inA  (a_q[3:0]),
    .inB  (b_q[3:0]),
    .bIn  (borrow_q),
    .diff (nib_diff),
    .bOut (nib_bout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    acc_d    = acc_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = inA;
          b_d      = inB;
          borrow_d = bIn;
          a_msb_d  = inA[WIDTH-1];
          b_msb_d  = inB[WIDTH-1];
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = {nib_diff, acc_q[WIDTH-1:NIBBLE]};
        a_d      = a_q >> NIBBLE;
        b_d      = b_q >> NIBBLE;
        borrow_d = nib_bout;
        idx_d    = idx_q + 1'b1;
        // Visible results move only here, so RUN keeps showing the previous ones.
        if (idx_q == LAST) begin
          diff_d  = acc_d;
          bout_d  = nib_bout;
          ovf_d   = (a_msb_q ^ b_msb_q) & (nib_diff[3] ^ a_msb_q);
          zero_d  = (acc_d == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      acc_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      acc_q    <= acc_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bOut = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Self-checking bench for sub16_serial: directed cases, handshake, reset
// abort and randomized operands against an arithmetic reference model.
module tb_sub16_serial;

  localparam int W = 16;
  localparam int LAT = W / 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         bIn;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bOut;
  logic         ovf;
  logic         zero;

  int checkCount;
  int failCount;

  sub16_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .inA   (inA),
    .inB   (inB),
    .bIn   (bIn),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bOut  (bOut),
    .ovf   (ovf),
    .zero  (zero)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, unsigned compare and signed range.
  task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          output logic [W-1:0] d, output logic bo, output logic ov,
                          output logic z);
    longint ua, ub, sa, sb, full, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= (64'sd1 <<< (W - 1))) ? ua - (64'sd1 <<< W) : ua;
    sb = (ub >= (64'sd1 <<< (W - 1))) ? ub - (64'sd1 <<< W) : ub;
    full = ua - ub - longint'(bi);
    if (full < 0) full = full + (64'sd1 <<< W);
    d = W'(full);
    bo = (ua < ub + longint'(bi));
    sres = sa - sb - longint'(bi);
    ov = (sres > (64'sd1 <<< (W - 1)) - 1) || (sres < -(64'sd1 <<< (W - 1)));
    z = (d == '0);
  endtask

  // Run one operation: start, watch the RUN cycles, then check results and pulse width.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                               input bit midPulse);
    logic [W-1:0] expD, prevDiff;
    logic expB, expO, expZ;
    int cycles;
    refModel(a, b, bi, expD, expB, expO, expZ);
    @(negedge clk);
    prevDiff = diff;
    inA = a;
    inB = b;
    bIn = bi;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    inA = W'($urandom);
    inB = W'($urandom);
    bIn = 1'b1;
    cycles = 0;
    while (!done && cycles <= LAT + 4) begin
      checkOutput("busy_run", busy, 1'b1);
      checkOutput("diff_hold", diff, prevDiff);
      if (midPulse && cycles == 1) start = 1'b1;
      else start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checkOutput("latency", cycles, LAT);
    checkOutput("busy_done", busy, 1'b0);
    checkOutput("diff", diff, expD);
    checkOutput("bOut", bOut, expB);
    checkOutput("ovf", ovf, expO);
    checkOutput("zero", zero, expZ);
    @(negedge clk);
    checkOutput("done_pulse", done, 1'b0);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_diff"}, diff, '0);
    checkOutput({tag, "_bOut"}, bOut, 1'b0);
    checkOutput({tag, "_ovf"}, ovf, 1'b0);
    checkOutput({tag, "_zero"}, zero, 1'b0);
  endtask

  // Main sequence: reset, directed vectors, handshake, reset abort, random sweep.
  initial begin
    logic [W-1:0] expD;
    logic expB, expO, expZ;
    int doneSeen;
    checkCount = 0;
    failCount = 0;
    rst_n = 1'b0;
    start = 1'b0;
    inA = '0;
    inB = '0;
    bIn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleZero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkIdleZero("idle");

    applyStimulus(16'h1234, 16'h0234, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
    applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    // Mid-RUN start pulse with different operands must be ignored.
    applyStimulus(16'h0050, 16'h0030, 1'b0, 1'b1);

    // Start held high: results every LAT+1 cycles, re-capture only in the done cycle.
    @(negedge clk);
    inA = 16'h4321;
    inB = 16'h1111;
    bIn = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inA = 16'h0100;
    inB = 16'h0200;
    doneSeen = 0;
    for (int i = 1; i <= 2 * LAT + 1; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == LAT) begin
        checkOutput("b2b_done1", done, 1'b1);
        checkOutput("b2b_diff1", diff, 16'h3210);
      end else if (i == 2 * LAT + 1) begin
        refModel(16'h0100, 16'h0200, 1'b0, expD, expB, expO, expZ);
        checkOutput("b2b_done2", done, 1'b1);
        checkOutput("b2b_diff2", diff, expD);
        checkOutput("b2b_bOut2", bOut, expB);
        start = 1'b0;
      end else begin
        if (done) doneSeen++;
      end
    end
    checkOutput("b2b_extra_done", doneSeen, 0);
    repeat (2) @(negedge clk);

    // Reset sampled at E2 of an operation abandons it without a done.
    @(negedge clk);
    inA = 16'h9999;
    inB = 16'h1111;
    bIn = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkIdleZero("rst_abort");
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("rst_no_done", doneSeen, 0);
    applyStimulus(16'd5, 16'd3, 1'b0, 1'b0);

    for (int n = 0; n < 4000; n++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
